// File: rtl/reg_wr_arb.sv
// reg_wr_arb: round-robin write arbiter with lockable ownership in front of one shared register
module reg_wr_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int RSTN_VALUE = 0
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_lock,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic                          o_upd,
  output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
  output logic                          o_locked
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state;
  logic [IW-1:0] ptr, owner, gid, idx;
  logic acc;
  int j;
  assign o_locked = (state == LOCKED);
  always_comb begin
    gid = owner;
    acc = 1'b0;
    j = 0;
    idx = '0;
    if (state == LOCKED) acc = i_req_valid[owner];
    else
      for (int i = 0; i < NUM_REQ; i++) begin
        j = int'(ptr) + i;
        j = (j >= NUM_REQ) ? j - NUM_REQ : j;
        idx = IW'(j);
        if (!acc && i_req_valid[idx]) begin
          acc = 1'b1;
          gid = idx;
        end
      end
    acc = acc & i_rst_n;
    o_req_ready = acc ? NUM_REQ'(1) << gid : '0;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_data <= DATA_WIDTH'(RSTN_VALUE);
      o_upd <= 1'b0;
      o_grant_id <= '0;
      ptr <= '0;
      owner <= '0;
      state <= IDLE;
    end else begin
      o_upd <= acc;
      if (acc) begin
        o_data <= i_req_data[gid*DATA_WIDTH +: DATA_WIDTH];
        o_grant_id <= gid;
        ptr <= (gid == IW'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
        if (state == IDLE && i_req_lock[gid]) begin
          state <= LOCKED;
          owner <= gid;
        end else if (state == LOCKED && !i_req_lock[gid]) state <= IDLE;
      end
    end
endmodule

// File: doc/reg_wr_arb.md
REG_WR_ARB -- requirements
Module: reg_wr_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of shared register and of each requester's data.
REQ-002 Parameter NUM_REQ, default 4: number of requesters, legal range 2..16.
REQ-003 Parameter RSTN_VALUE, default 0: reset value of the shared register.
REQ-004 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_req_valid  input  NUM_REQ  per-requester write request; bit k belongs to requester k.
REQ-007 i_req_lock  input  NUM_REQ  per-requester lock request; sampled only on that requester's accepted write.
REQ-008 i_req_data  input  NUM_REQ*DATA_WIDTH  write data; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 o_req_ready  output  NUM_REQ  one-hot-or-zero grant; combinational from i_req_valid and internal state.
REQ-010 o_data  output  DATA_WIDTH  current value of the shared register.
REQ-011 o_upd  output  1  registered pulse, high for the one cycle after a write is accepted.
REQ-012 o_grant_id  output  $clog2(NUM_REQ)  index of the requester whose write was last accepted.
REQ-013 o_locked  output  1  high while the FSM is in LOCKED.

Function
REQ-014 A write SHALL be accepted for requester k in a cycle where i_req_valid[k] and o_req_ready[k] are both high.
REQ-015 At most one o_req_ready bit SHALL be high in any cycle; o_req_ready[k] SHALL never be high while i_req_valid[k] is low.
REQ-016 FSM SHALL have two states: IDLE and LOCKED; o_locked = (state == LOCKED).
REQ-017 In IDLE, ready SHALL go to the first valid requester found searching upward from the round-robin pointer ptr, wrapping from NUM_REQ-1 to 0.
REQ-018 In LOCKED, ready SHALL go only to the owner, when the owner's valid is high; all other requesters SHALL see ready low.
REQ-019 On an accepted write from k: o_data <= data of k, o_grant_id <= k, o_upd <= 1, ptr <= (k+1) mod NUM_REQ; new o_data SHALL be visible the cycle after acceptance (latency 1).
REQ-020 In cycles with no accepted write, o_data, o_grant_id, ptr SHALL hold and o_upd SHALL be 0.
REQ-021 IDLE -> LOCKED when a write from k is accepted with i_req_lock[k]=1; owner <= k.
REQ-022 LOCKED -> IDLE when a write from the owner is accepted with i_req_lock[owner]=0; that write SHALL still update o_data.
REQ-023 LOCKED with owner write accepted and lock still 1 SHALL remain LOCKED with the same owner.
REQ-024 In LOCKED, owner valid low SHALL NOT release the lock; no write is accepted and state holds.
REQ-025 ptr SHALL wrap: acceptance from NUM_REQ-1 sets ptr to 0.
REQ-026 Back-to-back accepted writes on consecutive cycles SHALL each produce o_upd high; o_upd SHALL stay high across them.
REQ-027 i_req_data and i_req_lock of non-granted requesters SHALL have no effect.

Reset
REQ-028 While i_rst_n is low, asynchronously: o_data = RSTN_VALUE, o_upd = 0, o_grant_id = 0, ptr = 0, owner = 0, state = IDLE.
REQ-029 Reset asserted mid-lock SHALL drop to IDLE immediately, o_locked = 0, with no write accepted in that cycle (o_req_ready all 0 during reset).
REQ-030 First write after reset release SHALL be arbitrated from ptr = 0.

Verification
REQ-031 Reset then i_req_valid=4'b1111, data k = 32'h100+k, no lock, 4 cycles -> grants 0,1,2,3 in order; o_data 0x100..0x103 one cycle later each; o_upd high 4 cycles.
REQ-032 After grant to requester 3, i_req_valid=4'b1001 -> ptr wrapped to 0, requester 0 granted, o_grant_id=0.
REQ-033 Requester 2 writes 32'hA5A5A5A5 with lock=1, then valid=4'b1111 for 3 cycles with req2 lock=1 -> only req2 ready, o_locked=1; req2 write with lock=0 -> o_locked=0 next cycle, next grant to requester 3.
REQ-034 LOCKED owner 1, owner valid low, others valid -> o_req_ready=0, o_data holds, o_upd=0, o_locked stays 1.
REQ-035 Assert i_rst_n low asynchronously while LOCKED with o_data=32'hDEADBEEF -> o_data=0, o_locked=0, o_upd=0 without waiting for a clock edge.
REQ-036 Randomized valid/lock/data, 10k cycles -> scoreboard confirms one-hot-or-zero ready, no starvation in IDLE within NUM_REQ accepts, and o_data equals last accepted data.
